// File: rtl/base_initsink.sv
// base_initsink: sink for the memory-init index stream.
// Writes INIT_VAL at each received index and flags order/overrun errors.
module base_initsink #(
    parameter int              LOG_COUNT = 1,
    parameter int              COUNT     = 2 ** LOG_COUNT,
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] INIT_VAL = {WIDTH{1'b0}}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 din_v,
    input  logic [0:LOG_COUNT-1] din_d,
    output logic                 din_r,
    output logic                 wr_v,
    output logic [LOG_COUNT-1:0] wr_a,
    output logic [WIDTH-1:0]     wr_d,
    input  logic                 wr_r,
    output logic                 init_done,
    output logic                 init_err,
    output logic [LOG_COUNT-1:0] err_idx
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [LOG_COUNT-1:0] LAST_IDX = LOG_COUNT'(COUNT - 1);

    state_t               state_q, state_d;
    logic [LOG_COUNT-1:0] exp_q, exp_d;
    logic                 wr_v_q, wr_v_d;
    logic [LOG_COUNT-1:0] wr_a_q, wr_a_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [LOG_COUNT-1:0] eidx_q, eidx_d;
    logic [LOG_COUNT-1:0] din_val;
    logic                 din_r_c;
    logic                 in_xfer;
    logic                 wr_xfer;
    logic                 bad;

    // Received index as a plain number (port is MSB-at-bit-0).
    assign din_val = din_d;

    // Ready depends on phase; held low while reset is asserted.
    always_comb begin
        din_r_c = 1'b0;
        unique case (state_q)
            FILL:    din_r_c = ~wr_v_q | wr_r;
            DRAIN:   din_r_c = 1'b0;
            DONE:    din_r_c = 1'b1;
            default: din_r_c = 1'b0;
        endcase
        din_r_c = din_r_c & reset;
    end

    assign in_xfer = din_v & din_r_c;
    assign wr_xfer = wr_v_q & wr_r;

    // Next state: buffer load/unload, ordering check, completion.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        wr_v_d  = wr_v_q;
        wr_a_d  = wr_a_q;
        done_d  = done_q;
        bad     = 1'b0;

        if (wr_xfer) begin
            wr_v_d = 1'b0;
        end

        unique case (state_q)
            FILL: begin
                if (in_xfer) begin
                    wr_v_d = 1'b1;
                    wr_a_d = din_val;
                    bad    = (din_val != exp_q);
                    if (exp_q == '0) begin
                        state_d = DRAIN;
                    end else begin
                        exp_d = exp_q - 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (wr_xfer) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                bad = in_xfer;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Sticky error flag; the index of only the first bad beat is kept.
    always_comb begin
        err_d  = err_q;
        eidx_d = eidx_q;
        if (bad) begin
            err_d = 1'b1;
            if (!err_q) begin
                eidx_d = din_val;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= FILL;
            exp_q   <= LAST_IDX;
            wr_v_q  <= 1'b0;
            wr_a_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            eidx_q  <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            wr_v_q  <= wr_v_d;
            wr_a_q  <= wr_a_d;
            done_q  <= done_d;
            err_q   <= err_d;
            eidx_q  <= eidx_d;
        end
    end

    assign din_r     = din_r_c;
    assign wr_v      = wr_v_q;
    assign wr_a      = wr_a_q;
    assign wr_d      = INIT_VAL;
    assign init_done = done_q;
    assign init_err  = err_q;
    assign err_idx   = eidx_q;

endmodule
